wb_stage: RTL and testbench

- Memory-to-writeback pipeline stage of the RV64I core; the sole driver of the register file write port (write, writenum, write_data).
- Registers the MEM-stage result and selects between the ALU result and load data. Load data is byte-selected and sign/zero-extended here.
- Detects misaligned and illegal loads, issues at most one register-file write per instruction, and counts retired instructions.
- The register file clears every register when a write arrives with writenum 0. This block therefore never asserts write with writenum 0.

---
 rtl/rv64_pkg.sv | 33 +++
 rtl/load_align.sv | 53 +++++
 rtl/wb_stage.sv | 110 +++++++++++
 tb/tb_wb_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// Shared RV64I definitions: data width, load funct3 encodings, exception
// cause codes and the writeback stage entry payload.
package rv64_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_f3_e;

  localparam logic [1:0] EXC_NONE        = 2'b00;
  localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_LD_ILLEGAL  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
    logic [2:0]       funct3;
    logic [2:0]       addr_lo;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  load_data;
  } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction and alignment/legality check.
// Ports:
//   funct3     - load type
//   addr_lo    - effective address bits [2:0]
//   load_data  - raw aligned doubleword from memory
//   data       - byte-selected, sign/zero-extended result
//   misaligned - access not naturally aligned for its size
//   illegal    - funct3 is not a load encoding
module load_align
  import rv64_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);

  logic [5:0]  sh_b;
  logic [5:0]  sh_h;
  logic [5:0]  sh_w;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  // Bit offsets of the addressed byte, halfword and word lanes.
  assign sh_b = {addr_lo, 3'b000};
  assign sh_h = {addr_lo[2:1], 4'b0000};
  assign sh_w = {addr_lo[2], 5'b00000};

  assign b = load_data[sh_b +: 8];
  assign h = load_data[sh_h +: 16];
  assign w = load_data[sh_w +: 32];

  // Extension and alignment per load type; 111 falls to default as illegal.
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      LB:  data = {{56{b[7]}}, b};
      LH:  begin data = {{48{h[15]}}, h}; misaligned = addr_lo[0];          end
      LW:  begin data = {{32{w[31]}}, w}; misaligned = |addr_lo[1:0];       end
      LD:  begin data = load_data;        misaligned = |addr_lo;            end
      LBU: data = {56'b0, b};
      LHU: begin data = {48'b0, h};       misaligned = addr_lo[0];          end
      LWU: begin data = {32'b0, w};       misaligned = |addr_lo[1:0];       end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Memory-to-writeback stage: registers the MEM result, selects ALU or load
// data, raises load exceptions, drives the register file write port once per
// instruction and counts retired instructions.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   stall, flush        - hold the entry / drop the incoming instruction
//   in_*                - instruction offered by MEM
//   write, writenum,
//   write_data          - register file write port (never targets x0)
//   exc_valid,exc_cause - one-cycle load exception report
//   retire_count        - committed instruction count, wraps
module wb_stage
  import rv64_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_reg_write,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [2:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_load_data,
  output logic             write,
  output logic [REG_W-1:0] writenum,
  output logic [XLEN-1:0]  write_data,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retire_count
);

  wb_entry_t        entry_q;
  logic             committed_q;
  logic [CNT_W-1:0] count_q;

  logic             commit;
  logic             err;
  logic             mis;
  logic [XLEN-1:0]  ld_data;
  logic             ld_mis;
  logic             ld_ill;

  load_align u_load_align (
    .funct3     (entry_q.funct3),
    .addr_lo    (entry_q.addr_lo),
    .load_data  (entry_q.load_data),
    .data       (ld_data),
    .misaligned (ld_mis),
    .illegal    (ld_ill)
  );

  // An entry commits once; a stall after commit keeps it from repeating.
  assign commit = entry_q.valid & ~committed_q;
  assign mis    = entry_q.is_load & ld_mis;
  assign err    = entry_q.is_load & (ld_ill | ld_mis);

  // Stage register, commit tracking and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q     <= '0;
      committed_q <= 1'b0;
      count_q     <= '0;
    end else begin
      if (flush) begin
        entry_q.valid <= 1'b0;
        committed_q   <= 1'b0;
      end else if (stall) begin
        committed_q <= committed_q | commit;
      end else begin
        entry_q.valid      <= in_valid;
        entry_q.rd         <= in_rd;
        entry_q.reg_write  <= in_reg_write;
        entry_q.is_load    <= in_is_load;
        entry_q.funct3     <= in_funct3;
        entry_q.addr_lo    <= in_addr_lo;
        entry_q.alu_result <= in_alu_result;
        entry_q.load_data  <= in_load_data;
        committed_q        <= 1'b0;
      end
      // The current entry retires even when the incoming one is flushed.
      if (commit & ~err) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Write port and exception outputs decoded from the entry; x0 never written.
  always_comb begin
    write      = commit & entry_q.reg_write & (entry_q.rd != '0) & ~err;
    writenum   = '0;
    write_data = '0;
    exc_valid  = commit & err;
    exc_cause  = EXC_NONE;
    if (write) begin
      writenum   = entry_q.rd;
      write_data = entry_q.is_load ? ld_data : entry_q.alu_result;
    end
    if (exc_valid) begin
      exc_cause = mis ? EXC_LD_MISALIGN : EXC_LD_ILLEGAL;
    end
  end

  assign retire_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_alu_result;
  logic [63:0] in_load_data;
  logic        write;
  logic [4:0]  writenum;
  logic [63:0] write_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [63:0] retire_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the instruction held by the stage.
  logic        m_valid = 1'b0;
  logic        m_done  = 1'b0;
  logic [4:0]  m_rd    = '0;
  logic        m_rw    = 1'b0;
  logic        m_ld    = 1'b0;
  logic [2:0]  m_f3    = '0;
  logic [2:0]  m_a     = '0;
  logic [63:0] m_alu   = '0;
  logic [63:0] m_data  = '0;
  logic [63:0] m_cnt   = '0;

  wb_stage #(.CNT_W(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_is_load    (in_is_load),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .in_load_data  (in_load_data),
    .write         (write),
    .writenum      (writenum),
    .write_data    (write_data),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load result: pick the naturally aligned lane, then extend.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] a,
                                           input logic [63:0] d);
    logic [63:0] sb, sh, sw;
    sb = d >> (8 * a);
    sh = d >> (8 * (a - (a % 2)));
    sw = d >> (8 * (a - (a % 4)));
    case (f3)
      3'd0: return {{56{sb[7]}}, sb[7:0]};
      3'd1: return {{48{sh[15]}}, sh[15:0]};
      3'd2: return {{32{sw[31]}}, sw[31:0]};
      3'd3: return d;
      3'd4: return {56'b0, sb[7:0]};
      3'd5: return {48'b0, sh[15:0]};
      3'd6: return {32'b0, sw[31:0]};
      default: return 64'b0;
    endcase
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [2:0] a);
    case (f3)
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2, 3'd6: return (a % 4) != 0;
      3'd3:       return a != 0;
      default:    return 1'b0;
    endcase
  endfunction

  // Compare every output against what the model's held instruction implies.
  task automatic check_outputs();
    logic        c, mis, ill, e, w;
    logic [63:0] wd;
    logic [1:0]  cause;
    c     = m_valid && !m_done;
    ill   = (m_f3 == 3'd7);
    mis   = m_ld && ref_misaligned(m_f3, m_a);
    e     = m_ld && (ill || mis);
    w     = c && m_rw && (m_rd != 0) && !e;
    wd    = !w ? 64'b0 : (m_ld ? ref_load(m_f3, m_a, m_data) : m_alu);
    cause = (c && e) ? (mis ? 2'b01 : 2'b10) : 2'b00;
    check_eq("write", 64'(write), 64'(w));
    check_eq("writenum", 64'(writenum), w ? 64'(m_rd) : 64'b0);
    check_eq("write_data", write_data, wd);
    check_eq("exc_valid", 64'(exc_valid), 64'(c && e));
    check_eq("exc_cause", 64'(exc_cause), 64'(cause));
    check_eq("retire_count", retire_count, m_cnt);
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic c, e;
    c = m_valid && !m_done;
    e = m_ld && ((m_f3 == 3'd7) || ref_misaligned(m_f3, m_a));
    if (reset) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_cnt   = '0;
    end else begin
      if (c && !e) m_cnt = m_cnt + 64'd1;
      if (flush) begin
        m_valid = 1'b0;
        m_done  = 1'b0;
      end else if (stall) begin
        m_done = m_done || c;
      end else begin
        m_valid = in_valid;
        m_done  = 1'b0;
        m_rd    = in_rd;
        m_rw    = in_reg_write;
        m_ld    = in_is_load;
        m_f3    = in_funct3;
        m_a     = in_addr_lo;
        m_alu   = in_alu_result;
        m_data  = in_load_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_rd = '0; in_reg_write = 1'b0; in_is_load = 1'b0; in_funct3 = '0;
    in_addr_lo = '0; in_alu_result = '0; in_load_data = '0;
  endtask

  task automatic offer(input logic [4:0] rd, input logic rw, input logic ld,
                       input logic [2:0] f3, input logic [2:0] a,
                       input logic [63:0] alu, input logic [63:0] data);
    idle();
    in_valid = 1'b1; in_rd = rd; in_reg_write = rw; in_is_load = ld;
    in_funct3 = f3; in_addr_lo = a; in_alu_result = alu; in_load_data = data;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_write", 64'(write), 64'd0);
    check_eq("rst_count", retire_count, 64'd0);

    // ALU write, then held by stall.
    offer(5'd5, 1'b1, 1'b0, 3'd0, 3'd0, 64'h1234, 64'h0);
    tick();
    check_eq("alu_write", 64'(write), 64'd1);
    check_eq("alu_num", 64'(writenum), 64'd5);
    check_eq("alu_data", write_data, 64'h1234);
    idle(); stall = 1'b1;
    tick();
    check_eq("stall_write", 64'(write), 64'd0);
    check_eq("stall_count", retire_count, 64'd1);
    tick();
    tick();
    check_eq("stall3_count", retire_count, 64'd1);

    // x0 destination retires without writing.
    offer(5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'h55, 64'h0);
    tick();
    check_eq("x0_write", 64'(write), 64'd0);
    check_eq("x0_num", 64'(writenum), 64'd0);
    idle();
    tick();
    check_eq("x0_count", retire_count, 64'd2);

    // Loads.
    offer(5'd9, 1'b1, 1'b1, 3'd0, 3'd3, 64'h0, 64'h0000_0000_8000_0000);
    tick();
    check_eq("lb_data", write_data, 64'hFFFF_FFFF_FFFF_FF80);
    offer(5'd9, 1'b1, 1'b1, 3'd4, 3'd3, 64'h0, 64'h0000_0000_8000_0000);
    tick();
    check_eq("lbu_data", write_data, 64'h80);
    offer(5'd9, 1'b1, 1'b1, 3'd6, 3'd4, 64'h0, 64'hDEAD_BEEF_0000_0000);
    tick();
    check_eq("lwu_data", write_data, 64'h0000_0000_DEAD_BEEF);
    idle();
    tick();
    check_eq("load_count", retire_count, 64'd5);

    // Misaligned and illegal loads.
    offer(5'd7, 1'b1, 1'b1, 3'd3, 3'd4, 64'h0, 64'h1);
    tick();
    check_eq("ldmis_write", 64'(write), 64'd0);
    check_eq("ldmis_exc", 64'(exc_valid), 64'd1);
    check_eq("ldmis_cause", 64'(exc_cause), 64'd1);
    idle();
    tick();
    check_eq("ldmis_pulse", 64'(exc_valid), 64'd0);
    offer(5'd7, 1'b1, 1'b1, 3'd7, 3'd0, 64'h0, 64'h1);
    tick();
    check_eq("ill_cause", 64'(exc_cause), 64'd2);
    idle();
    tick();
    check_eq("exc_count", retire_count, 64'd5);

    // Flush kills the incoming B but A still commits.
    offer(5'd10, 1'b1, 1'b0, 3'd0, 3'd0, 64'hA, 64'h0);
    tick();
    check_eq("flushA_write", 64'(write), 64'd1);
    offer(5'd11, 1'b1, 1'b0, 3'd0, 3'd0, 64'hB, 64'h0);
    flush = 1'b1;
    tick();
    check_eq("flushB_write", 64'(write), 64'd0);
    idle();
    tick();
    check_eq("flush_count", retire_count, 64'd6);

    // Reset in the middle of a stall.
    offer(5'd12, 1'b1, 1'b0, 3'd0, 3'd0, 64'hC, 64'h0);
    tick();
    idle(); stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_eq("rst_stall_write", 64'(write), 64'd0);
    check_eq("rst_stall_count", retire_count, 64'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      reset         = ($urandom_range(0, 99) < 2);
      stall         = ($urandom_range(0, 99) < 25);
      flush         = ($urandom_range(0, 99) < 10);
      in_valid      = ($urandom_range(0, 99) < 80);
      in_rd         = 5'($urandom_range(0, 31));
      in_reg_write  = ($urandom_range(0, 99) < 80);
      in_is_load    = ($urandom_range(0, 99) < 50);
      in_funct3     = 3'($urandom_range(0, 7));
      in_addr_lo    = ($urandom_range(0, 99) < 50) ? 3'd0 : 3'($urandom_range(0, 7));
      in_alu_result = {$urandom, $urandom};
      in_load_data  = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
